router_fsm_nch: RTL and testbench

ROUTER_FSM_NCH -- requirements
Module: router_fsm_nch

---
 rtl/router_fsm_nch.sv | 169 ++++++++++++++++
 tb/tb_router_fsm_nch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_nch.sv
`default_nettype none
// ============================================================================
// Module   : router_fsm_nch
// Brief    : Packet router control FSM steering header-addressed packets into
//            one of NUM_CH FIFOs. Define ROUTER_WAIT_TIMEOUT_EN to enable the
//            WAIT_TILL_EMPTY timeout (drops the packet after 2**TMO_W-1 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module router_fsm_nch #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2,
  parameter int TMO_W  = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              addr_err,
  output logic              wait_tmo
);

  typedef enum logic [3:0] {
    S_DECODE_ADDRESS     = 4'd0,
    S_LOAD_FIRST_DATA    = 4'd1,
    S_LOAD_DATA          = 4'd2,
    S_LOAD_PARITY        = 4'd3,
    S_FIFO_FULL_STATE    = 4'd4,
    S_LOAD_AFTER_FULL    = 4'd5,
    S_WAIT_TILL_EMPTY    = 4'd6,
    S_CHECK_PARITY_ERROR = 4'd7,
    S_DROP_PACKET        = 4'd8
  } state_t;

  localparam logic [ADDR_W:0] c_NUM_CH = (ADDR_W+1)'(NUM_CH);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_sel_vld;
  logic                r_addr_err;
  logic [NUM_CH-1:0]   w_hdr_oh;
  logic [NUM_CH-1:0]   w_addr_oh;
  logic                w_hdr_ok;
  logic                w_sel_empty;
  logic                w_sr_hit;
  logic                w_tmo_fire;

  assign w_hdr_ok = ({1'b0, data_in} < c_NUM_CH);

  always_comb begin
    w_hdr_oh  = '0;
    w_addr_oh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hdr_oh[i]  = ({1'b0, data_in} == (ADDR_W+1)'(i));
      w_addr_oh[i] = ({1'b0, r_addr}  == (ADDR_W+1)'(i));
    end
  end

  // ch_sel is zero outside packet states, so these only see the latched channel
  assign ch_sel      = w_addr_oh & {NUM_CH{r_sel_vld}};
  assign w_sel_empty = |(fifo_empty & ch_sel);
  assign w_sr_hit    = |(soft_reset & ch_sel);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_wait_tmo;

  // Fires on the edge where the counter would reach 2**TMO_W-1
  assign w_tmo_fire = (r_state == S_WAIT_TILL_EMPTY) && !w_sel_empty &&
                      !w_sr_hit && (r_tmo_cnt == c_TMO_LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_tmo_cnt  <= '0;
      r_wait_tmo <= 1'b0;
    end else begin
      r_tmo_cnt  <= (r_state == S_WAIT_TILL_EMPTY) ? r_tmo_cnt + 1'b1 : '0;
      r_wait_tmo <= w_tmo_fire;
    end
  end

  assign wait_tmo = r_wait_tmo;
`else
  assign w_tmo_fire = 1'b0;
  assign wait_tmo   = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (!w_hdr_ok)                  w_next = S_DROP_PACKET;
          else if (|(fifo_empty & w_hdr_oh)) w_next = S_LOAD_FIRST_DATA;
          else                            w_next = S_WAIT_TILL_EMPTY;
        end
      end
      S_LOAD_FIRST_DATA:    w_next = S_LOAD_DATA;
      S_LOAD_DATA: begin
        if (fifo_full)       w_next = S_FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = S_LOAD_PARITY;
      end
      S_LOAD_PARITY:        w_next = S_CHECK_PARITY_ERROR;
      S_CHECK_PARITY_ERROR: w_next = fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
      S_FIFO_FULL_STATE:    if (!fifo_full) w_next = S_LOAD_AFTER_FULL;
      S_LOAD_AFTER_FULL: begin
        if (parity_done)        w_next = S_DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = S_LOAD_PARITY;
        else                    w_next = S_LOAD_DATA;
      end
      S_WAIT_TILL_EMPTY: begin
        if (w_sel_empty)     w_next = S_LOAD_FIRST_DATA;
        else if (w_tmo_fire) w_next = S_DROP_PACKET;
      end
      S_DROP_PACKET:        if (!pkt_valid) w_next = S_DECODE_ADDRESS;
      default:              w_next = S_DECODE_ADDRESS;
    endcase
    if (w_sr_hit) w_next = S_DECODE_ADDRESS;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= S_DECODE_ADDRESS;
      r_addr     <= '0;
      r_sel_vld  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr_err <= (r_state == S_DECODE_ADDRESS) && pkt_valid && !w_hdr_ok;
      if (r_state == S_DECODE_ADDRESS) begin
        if (pkt_valid) r_addr <= data_in;
        r_sel_vld <= pkt_valid && w_hdr_ok;
      end else if (w_next == S_DECODE_ADDRESS || w_next == S_DROP_PACKET) begin
        r_sel_vld <= 1'b0;
      end
    end
  end

  assign detect_add    = (r_state == S_DECODE_ADDRESS);
  assign lfd_state     = (r_state == S_LOAD_FIRST_DATA);
  assign ld_state      = (r_state == S_LOAD_DATA);
  assign laf_state     = (r_state == S_LOAD_AFTER_FULL);
  assign full_state    = (r_state == S_FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == S_CHECK_PARITY_ERROR);
  assign write_enb_reg = (r_state == S_LOAD_DATA) || (r_state == S_LOAD_PARITY) ||
                         (r_state == S_LOAD_AFTER_FULL);
  assign busy          = (r_state == S_LOAD_FIRST_DATA)    || (r_state == S_LOAD_PARITY)     ||
                         (r_state == S_FIFO_FULL_STATE)    || (r_state == S_LOAD_AFTER_FULL) ||
                         (r_state == S_WAIT_TILL_EMPTY)    || (r_state == S_CHECK_PARITY_ERROR);
  assign addr_err      = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_router_fsm_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_fsm_nch
// Brief    : Scoreboard bench for router_fsm_nch (directed + random stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_fsm_nch;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;
  localparam int TMO_W  = 3;
`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int M_DEC = 0, M_LFD = 1, M_LD = 2, M_LP = 3, M_FULL = 4,
                 M_LAF = 5, M_WAIT = 6, M_CPE = 7, M_DROP = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic [NUM_CH-1:0] fifo_empty, soft_reset;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy, addr_err, wait_tmo;
  logic [NUM_CH-1:0] ch_sel;

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .ch_sel(ch_sel),
    .addr_err(addr_err), .wait_tmo(wait_tmo)
  );

  typedef struct packed {
    logic [7:0]        dec;
    logic [NUM_CH-1:0] sel;
    logic [1:0]        ev;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t e;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model state: packet phase, selected channel (-1 = none), wait length
  int m_st = M_DEC, m_sel = -1, m_wcnt = 0;
  bit m_aerr = 1'b0, m_tmo = 1'b0;

  task automatic model_step(input logic rn, pv, input logic [ADDR_W-1:0] d,
                            input logic [NUM_CH-1:0] fe, input logic ff,
                            input logic [NUM_CH-1:0] sr, input logic pd, lpv);
    m_aerr = 1'b0;
    m_tmo  = 1'b0;
    if (!rn) begin
      m_st = M_DEC;
    end else if (!(m_st inside {M_DEC, M_DROP}) && m_sel >= 0 && sr[m_sel]) begin
      m_st = M_DEC;
    end else begin
      case (m_st)
        M_DEC: if (pv) begin
          if (int'(d) >= NUM_CH) begin
            m_st = M_DROP; m_aerr = 1'b1;
          end else begin
            m_sel = int'(d); m_wcnt = 0;
            m_st = fe[d] ? M_LFD : M_WAIT;
          end
        end
        M_LFD:  m_st = M_LD;
        M_LD:   if (ff) m_st = M_FULL; else if (!pv) m_st = M_LP;
        M_LP:   m_st = M_CPE;
        M_CPE:  m_st = ff ? M_FULL : M_DEC;
        M_FULL: if (!ff) m_st = M_LAF;
        M_LAF:  m_st = pd ? M_DEC : (lpv ? M_LP : M_LD);
        M_WAIT: if (fe[m_sel]) m_st = M_LFD;
                else begin
                  m_wcnt++;
                  if (TMO_EN && m_wcnt == (1 << TMO_W) - 1) begin
                    m_st = M_DROP; m_tmo = 1'b1;
                  end
                end
        M_DROP: if (!pv) m_st = M_DEC;
        default: m_st = M_DEC;
      endcase
    end
    if (m_st inside {M_DEC, M_DROP}) m_sel = -1;
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.dec = {m_st == M_DEC, m_st == M_LFD, m_st == M_LD, m_st == M_LAF,
             m_st == M_FULL, m_st == M_CPE, m_st inside {M_LD, M_LP, M_LAF},
             m_st inside {M_LFD, M_LP, M_FULL, M_LAF, M_WAIT, M_CPE}};
    e.sel = (m_sel >= 0) ? NUM_CH'(1 << m_sel) : '0;
    e.ev  = {m_aerr, m_tmo};
    return e;
  endfunction

  task automatic drive(input logic rn, pv, input logic [ADDR_W-1:0] d,
                       input logic [NUM_CH-1:0] fe, input logic ff,
                       input logic [NUM_CH-1:0] sr, input logic pd, lpv);
    sb_t t;
    @(posedge clock);
    #1;
    resetn = rn; pkt_valid = pv; data_in = d; fifo_empty = fe;
    fifo_full = ff; soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
    model_step(rn, pv, d, fe, ff, sr, pd, lpv);
    t.cyc = cyc + 1;
    t.e   = model_exp();
    sb_q.push_back(t);
  endtask

  // Monitor: outputs after edge N are compared mid-cycle against entry tagged N
  always @(negedge clock) begin
    sb_t  t;
    exp_t a;
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      t = sb_q.pop_front();
      a.dec = {detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy};
      a.sel = ch_sel;
      a.ev  = {addr_err, wait_tmo};
      n_checks += 3;
      if (a.dec !== t.e.dec) begin
        n_fail++;
        $display("FAIL state_decodes cyc=%0d got=%b exp=%b", cyc, a.dec, t.e.dec);
      end
      if (a.sel !== t.e.sel) begin
        n_fail++;
        $display("FAIL ch_sel cyc=%0d got=%b exp=%b", cyc, a.sel, t.e.sel);
      end
      if (a.ev !== t.e.ev) begin
        n_fail++;
        $display("FAIL addr_err_wait_tmo cyc=%0d got=%b exp=%b", cyc, a.ev, t.e.ev);
      end
    end
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_empty = '0;
    fifo_full = 1'b0; soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;

    repeat (2) drive(0, 0, 0, 3'b000, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);

    // Header to channel 1, then body, full mid-packet, resume via LOAD_PARITY
    drive(1, 1, 1, 3'b111, 0, 3'b000, 0, 0);
    repeat (3) drive(1, 1, 0, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 1, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 1, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 1);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);

    // Illegal address: drop 4 body bytes
    drive(1, 1, 3, 3'b111, 0, 3'b000, 0, 0);
    repeat (4) drive(1, 1, 0, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);

    // Channel 2 busy for 5 cycles, then the packet proceeds
    drive(1, 1, 2, 3'b011, 0, 3'b000, 0, 0);
    repeat (5) drive(1, 1, 0, 3'b011, 0, 3'b000, 0, 0);
    drive(1, 1, 0, 3'b111, 0, 3'b000, 0, 0);
    repeat (4) drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);

    // Channel 0 never drains: timeout (when enabled) or indefinite wait
    drive(1, 1, 0, 3'b110, 0, 3'b000, 0, 0);
    repeat (12) drive(1, 1, 0, 3'b110, 0, 3'b000, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);
    repeat (4) drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);

    // Soft reset: other channel ignored, own channel aborts; reset beats soft reset
    drive(1, 1, 1, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 1, 0, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 1, 0, 3'b111, 0, 3'b100, 0, 0);
    drive(1, 1, 0, 3'b111, 0, 3'b010, 0, 0);
    drive(1, 1, 1, 3'b111, 0, 3'b000, 0, 0);
    drive(1, 1, 0, 3'b111, 0, 3'b000, 0, 0);
    drive(0, 1, 2, 3'b111, 1, 3'b010, 0, 0);
    drive(1, 0, 0, 3'b111, 0, 3'b000, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(9) < 7),
            ADDR_W'($urandom_range(3)), NUM_CH'($urandom),
            ($urandom_range(3) == 0),
            ($urandom_range(19) == 0) ? NUM_CH'($urandom) : '0,
            ($urandom_range(3) == 0), ($urandom_range(3) == 0));
    end

    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
